// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives the instruction memory address and
// hands {pc, instr, pc+4} to decode over a registered valid/ready slot with a sticky fault.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc_plus4,
    output logic        fault,
    output logic [31:0] fault_pc
);

    // One bit wider than an address so the limit itself never wraps.
    localparam logic [32:0] LIMIT = 33'(IMEM_WORDS) * 33'd4;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc_plus4;
    } fetch_word_t;

    state_t      state;
    logic [31:0] pc;
    fetch_word_t out_q;

    logic free, accepted, pc_ok, redir_ok;

    assign imem_addr    = pc;
    assign out_pc       = out_q.pc;
    assign out_instr    = out_q.instr;
    assign out_pc_plus4 = out_q.pc_plus4;

    assign free     = !out_valid || out_ready;
    assign accepted = out_valid && out_ready;
    assign pc_ok    = {1'b0, pc} < LIMIT;
    assign redir_ok = (redirect_pc[1:0] == 2'b00) && ({1'b0, redirect_pc} < LIMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            out_q     <= '0;
            out_valid <= 1'b0;
            fault     <= 1'b0;
            fault_pc  <= '0;
        end else begin
            case (state)
                S_IDLE, S_RUN: begin
                    if (redirect_valid) begin
                        // Flush the slot; any same-cycle handshake still counts as taken.
                        out_valid <= 1'b0;
                        if (redir_ok) begin
                            pc    <= redirect_pc;
                            state <= S_RUN;
                        end else begin
                            fault    <= 1'b1;
                            fault_pc <= redirect_pc;
                            state    <= S_FAULT;
                        end
                    end else if (state == S_IDLE) begin
                        state <= S_RUN;
                    end else if (!pc_ok) begin
                        // Pending word stays visible until decode takes it.
                        fault    <= 1'b1;
                        fault_pc <= pc;
                        state    <= S_FAULT;
                        if (accepted) out_valid <= 1'b0;
                    end else if (free) begin
                        out_q.pc       <= pc;
                        out_q.instr    <= imem_rdata;
                        out_q.pc_plus4 <= pc + 32'd4;
                        out_valid      <= 1'b1;
                        pc             <= pc + 32'd4;
                    end
                end
                S_FAULT: begin
                    if (accepted) out_valid <= 1'b0;
                end
                default: state <= S_FAULT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a free-running instance and an end-of-memory instance,
// with accepted words checked against a queue of expected fetches.
module tb_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    int vectors = 0;
    int errors  = 0;

    // Instance A: RESET_PC = 0
    logic        rst_a, rv_a, ov_a, ordy_a, flt_a;
    logic [31:0] ia_a, rd_a, rpc_a, opc_a, oin_a, op4_a, fpc_a;
    assign rd_a = (ia_a < 32'h1000) ? mem[ia_a[11:2]] : 32'hDEAD_BEEF;

    fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(1024)) dut_a (
        .clk(clk), .rst(rst_a), .imem_addr(ia_a), .imem_rdata(rd_a),
        .redirect_valid(rv_a), .redirect_pc(rpc_a), .out_valid(ov_a), .out_ready(ordy_a),
        .out_pc(opc_a), .out_instr(oin_a), .out_pc_plus4(op4_a), .fault(flt_a), .fault_pc(fpc_a)
    );

    // Instance B: starts two words below the end of memory
    logic        rst_b, rv_b, ov_b, ordy_b, flt_b;
    logic [31:0] ia_b, rd_b, rpc_b, opc_b, oin_b, op4_b, fpc_b;
    assign rd_b = (ia_b < 32'h1000) ? mem[ia_b[11:2]] : 32'hDEAD_BEEF;

    fetch_stage #(.RESET_PC(32'hFF8), .IMEM_WORDS(1024)) dut_b (
        .clk(clk), .rst(rst_b), .imem_addr(ia_b), .imem_rdata(rd_b),
        .redirect_valid(rv_b), .redirect_pc(rpc_b), .out_valid(ov_b), .out_ready(ordy_b),
        .out_pc(opc_b), .out_instr(oin_b), .out_pc_plus4(op4_b), .fault(flt_b), .fault_pc(fpc_b)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a < 32'h1000) ? mem[a[11:2]] : 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] p);
        exp_t e;
        e.pc = p; e.instr = mem_word(p);
        qa.push_back(e);
    endtask

    task automatic push_b(input logic [31:0] p);
        exp_t e;
        e.pc = p; e.instr = mem_word(p);
        qb.push_back(e);
    endtask

    // Inputs are stable here; a handshake seen now is taken on the coming edge.
    task automatic tick();
        exp_t e;
        if (ov_a === 1'b1 && ordy_a) begin
            if (qa.size() == 0) chk("sb_a_unexpected_word", opc_a, 32'hFFFF_FFFF);
            else begin
                e = qa.pop_front();
                chk("sb_a_pc", opc_a, e.pc);
                chk("sb_a_instr", oin_a, e.instr);
                chk("sb_a_pc4", op4_a, e.pc + 32'd4);
            end
        end
        if (ov_b === 1'b1 && ordy_b) begin
            if (qb.size() == 0) chk("sb_b_unexpected_word", opc_b, 32'hFFFF_FFFF);
            else begin
                e = qb.pop_front();
                chk("sb_b_pc", opc_b, e.pc);
                chk("sb_b_instr", oin_b, e.instr);
                chk("sb_b_pc4", op4_b, e.pc + 32'd4);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 + 32'(i * 3);
        mem[0] = 32'h00500c63;
        mem[1] = 32'h00002083;
        mem[2] = 32'h01402103;

        rst_a = 1'b0; rv_a = 1'b0; rpc_a = '0; ordy_a = 1'b1;
        rst_b = 1'b0; rv_b = 1'b0; rpc_b = '0; ordy_b = 1'b1;

        // Reset state
        tick(); tick();
        chk("rst_valid", {31'd0, ov_a}, 32'd0);
        chk("rst_addr", ia_a, 32'h0);
        chk("rst_fault", {31'd0, flt_a}, 32'd0);
        chk("rst_out_pc", opc_a, 32'h0);
        chk("rst_out_instr", oin_a, 32'h0);
        chk("rst_out_pc4", op4_a, 32'h0);
        chk("rst_fault_pc", fpc_a, 32'h0);

        // Free run
        rst_a = 1'b1;
        tick();
        chk("idle_no_capture", {31'd0, ov_a}, 32'd0);
        push_a(32'h0);
        tick();
        chk("run0_valid", {31'd0, ov_a}, 32'd1);
        chk("run0_pc", opc_a, 32'h0);
        chk("run0_instr", oin_a, 32'h00500c63);
        chk("run0_pc4", op4_a, 32'h4);
        chk("run0_addr", ia_a, 32'h4);
        push_a(32'h4);
        tick();
        chk("run1_pc", opc_a, 32'h4);
        chk("run1_instr", oin_a, 32'h00002083);

        // Backpressure
        ordy_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_valid", {31'd0, ov_a}, 32'd1);
            chk("bp_pc", opc_a, 32'h4);
            chk("bp_instr", oin_a, 32'h00002083);
            chk("bp_addr", ia_a, 32'h8);
        end
        ordy_a = 1'b1;
        push_a(32'h8);
        tick();
        chk("bp_release_pc", opc_a, 32'h8);
        chk("bp_release_instr", oin_a, 32'h01402103);

        // Redirect with flush; the word at 8 is taken on the same edge
        rv_a = 1'b1; rpc_a = 32'h14;
        tick();
        rv_a = 1'b0;
        chk("redir_flush", {31'd0, ov_a}, 32'd0);
        chk("redir_addr", ia_a, 32'h14);
        push_a(32'h14);
        tick();
        chk("redir_cap_pc", opc_a, 32'h14);
        chk("redir_cap_instr", oin_a, mem_word(32'h14));

        // Misaligned redirect -> fault, then later redirect ignored
        rv_a = 1'b1; rpc_a = 32'h22;
        tick();
        chk("mis_fault", {31'd0, flt_a}, 32'd1);
        chk("mis_fault_pc", fpc_a, 32'h22);
        chk("mis_valid", {31'd0, ov_a}, 32'd0);
        chk("mis_addr_hold", ia_a, 32'h18);
        rpc_a = 32'h40;
        tick();
        tick();
        rv_a = 1'b0;
        chk("flt_redir_ignored", ia_a, 32'h18);
        chk("flt_sticky", {31'd0, flt_a}, 32'd1);
        chk("flt_no_capture", {31'd0, ov_a}, 32'd0);

        // Async reset mid-stall
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1; ordy_a = 1'b0;
        tick();
        tick();
        tick();
        chk("stall_valid", {31'd0, ov_a}, 32'd1);
        chk("stall_addr", ia_a, 32'h4);
        #2;
        rst_a = 1'b0;
        #1;
        chk("async_valid", {31'd0, ov_a}, 32'd0);
        chk("async_addr", ia_a, 32'h0);
        chk("async_out_pc", opc_a, 32'h0);
        chk("async_fault", {31'd0, flt_a}, 32'd0);
        tick();

        // End of memory
        rst_b = 1'b1;
        tick();
        chk("eom_idle_addr", ia_b, 32'hFF8);
        push_b(32'hFF8);
        tick();
        chk("eom_cap0_pc", opc_b, 32'hFF8);
        chk("eom_cap0_instr", oin_b, mem_word(32'hFF8));
        push_b(32'hFFC);
        tick();
        chk("eom_cap1_pc", opc_b, 32'hFFC);
        chk("eom_cap1_pc4", op4_b, 32'h1000);
        chk("eom_addr", ia_b, 32'h1000);
        ordy_b = 1'b0;
        tick();
        chk("eom_fault", {31'd0, flt_b}, 32'd1);
        chk("eom_fault_pc", fpc_b, 32'h1000);
        chk("eom_pending_held", {31'd0, ov_b}, 32'd1);
        chk("eom_pending_pc", opc_b, 32'hFFC);
        ordy_b = 1'b1;
        tick();
        chk("eom_drop_valid", {31'd0, ov_b}, 32'd0);
        tick();
        chk("eom_no_more", {31'd0, ov_b}, 32'd0);
        chk("eom_pc_frozen", ia_b, 32'h1000);

        chk("sb_a_drained", 32'(qa.size()), 32'd0);
        chk("sb_b_drained", 32'(qb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the processor. It sits directly upstream of the instruction memory and drives its word address.
- Holds the program counter, captures the returned instruction word, and presents {pc, instr, pc+4} to the decode stage through a registered valid/ready handshake.
- Accepts branch/jump redirects from execute and flags illegal fetch addresses with a sticky fault.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- IMEM_WORDS, 1024: instruction memory depth in words. Legal fetch range is 0 .. IMEM_WORDS*4-4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_addr  out  32  byte address to instruction memory; equals the pc register.
- imem_rdata  in  32  instruction word, combinational from imem_addr.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  32  redirect target byte address.
- out_valid  out  1  out_* fields hold a valid fetched instruction.
- out_ready  in  1  decode accepts the current out word.
- out_pc  out  32  address of out_instr.
- out_instr  out  32  fetched instruction.
- out_pc_plus4  out  32  out_pc+4, mod 2^32.
- fault  out  1  sticky illegal-address fault.
- fault_pc  out  32  offending address.

Behaviour:
- Reset (rst=0, async): pc=RESET_PC, state=IDLE, out_valid=0, out_pc=out_instr=out_pc_plus4=0, fault=0, fault_pc=0.
- imem_addr = pc at all times, combinational.
- States:
  - IDLE: one settle cycle after reset release. No capture. Next state is RUN.
  - RUN: normal fetching.
  - FAULT: terminal until reset.
- Slot free condition: free = !out_valid || out_ready.
- Priority inside RUN: redirect first, then limit check, then capture.
- RUN capture:
  - Applies when free is 1, redirect_valid is 0 and pc is legal.
  - out_instr<=imem_rdata, out_pc<=pc, out_pc_plus4<=pc+4, out_valid<=1, pc<=pc+4.
- RUN stall:
  - Applies when free is 0 and redirect_valid is 0.
  - pc and all out_* hold. out_valid stays 1, so fields are stable until accepted.
- Consumption only: when out_valid and out_ready are both 1 but no capture occurs, out_valid<=0.
- Throughput: one instruction per cycle while out_ready=1. Latency from pc to out_valid is 1 cycle.
- Redirect (redirect_valid=1 in IDLE or RUN), legal target:
  - Legal means redirect_pc[1:0]==0 and redirect_pc < IMEM_WORDS*4.
  - pc<=redirect_pc and out_valid<=0 (flush). Nothing is captured this cycle.
  - If out_valid and out_ready were both 1 that cycle, the transfer still counts as accepted.
  - IDLE then proceeds to RUN.
- Redirect, illegal target: pc holds, out_valid<=0, fault<=1, fault_pc<=redirect_pc, state<=FAULT.
- Sequential limit: in RUN, if pc >= IMEM_WORDS*4 (including wrap past 32'hFFFF_FFFC) with no redirect:
  - No capture; fault<=1, fault_pc<=pc, state<=FAULT.
  - A pending out word is still held until accepted. Its later acceptance clears out_valid.
- FAULT: no captures, pc frozen, redirects ignored, fault stays 1. Exit only through reset.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately, with no partial update.
- All arithmetic is 32-bit unsigned, mod 2^32.

Test Plan:
- Reset and free run: rst low 2 cycles then high, out_ready=1, memory words 0..2 = 32'h00500c63, 32'h00002083, 32'h01402103.
  - Cycle after IDLE: out_valid=1, out_pc=0, out_instr=32'h00500c63, out_pc_plus4=4.
  - Following cycles: pc 4, 8 with the matching words.
- Backpressure: out_ready=0 for 3 cycles while out_pc=4.
  - out_pc, out_instr and imem_addr (8) are stable.
  - On out_ready=1, the next word has out_pc=8 with no skip or duplicate.
- Redirect with flush: redirect_valid=1, redirect_pc=32'h14 while out_valid=1, out_pc=8.
  - Next cycle: out_valid=0, imem_addr=32'h14.
  - Cycle after: out_pc=32'h14, out_instr=mem[5].
- Misaligned redirect: redirect_pc=32'h22 → fault=1, fault_pc=32'h22, out_valid=0, pc unchanged. A later legal redirect is ignored.
- End of memory: RESET_PC=32'hFF8, IMEM_WORDS=1024, out_ready=1.
  - Captures at pc FF8 and FFC.
  - Then fault=1, fault_pc=32'h1000, out_valid drops after the last acceptance.
- Async reset mid-stall: assert rst while out_valid=1, out_ready=0 → out_valid=0, imem_addr=RESET_PC immediately, with no clock edge needed.
